agc_tpg: RTL and testbench
==========================

# agc_tpg

Time-pulse generator for the gate-level AGC model. Produces the twelve one-hot time pulses T01–T12 that define each memory cycle time (MCT), plus a per-pulse phase strobe, and drives them into the NOR-gate control matrix directly downstream. Handles power-on standby, GOJAM restart, monitor stop at MCT boundaries and, optionally, single-MCT stepping. It is the only sequential timing source the gate netlist sees.

## Interface
- `PHASES`, 2: clk cycles per time pulse; legal range 1–8.
- `IV_T`, 12'h000: value of `t` during reset; one-hot or zero.
- `clk`  input  1  master clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous reset, active-low; one clock domain only.
- `go`  input  1  level; leave standby and start running. Sampled at `clk`.
- `gojam`  input  1  level; restart request. Forces T12 completion, then a fresh T01.
- `stop`  input  1  level; monitor stop request. Honoured only at an MCT boundary.
- `mstep`  input  1  single-step pulse; released cycles only. Present only under `AGC_TPG_MSTEP_EN`.
- `t`  output  12  one-hot time pulse; bit 0 = T01, bit 11 = T12. Zero when not running.
- `ph`  output  3  phase index within the current pulse, 0..`PHASES`-1.
- `mct_end`  output  1  one-cycle strobe in the last phase of T12.
- `running`  output  1  high in state `RUN`.
- `mct_cnt`  output  16  completed-MCT counter; wraps 16'hFFFF -> 0.

## Operation
- States: `STBY`, `RUN`, `HALT`. Reset enters `STBY`.
- `STBY` -> `RUN` when `go`=1; first pulse is T01, `ph`=0.
- `RUN`: `ph` increments each clk. At `ph`=`PHASES`-1, `ph`->0 and `t` rotates left; T12 wraps to T01.
- `mct_end`=1 exactly when `t`=T12 and `ph`=`PHASES`-1. `mct_cnt` increments on the same edge that leaves T12.
- `stop`: sampled only in the `mct_end` cycle. If 1, the next state is `HALT` with `t`=0, so T12 always completes. Assertion mid-MCT has no effect until that MCT's end.
- `HALT` -> `RUN` at T01 when `stop`=0. Without the macro, `mstep` is absent and `HALT` is left only by deasserting `stop`.
- `gojam`: in `RUN`, jump to T12, `ph`=0, then finish normally. Already in T12: no jump, the sequence continues. In `HALT`/`STBY`: no effect. `gojam` has priority over `stop` for the jump; `stop` is still sampled at `mct_end`.
- `go` deasserted in `RUN`: no effect. Standby is left only through reset.
- Arithmetic: `ph` is 3 bits compared against `PHASES`-1. `mct_cnt` is a 16-bit modulo counter.

## Timing
- Reset values: `t`=`IV_T`, `ph`=0, `mct_end`=0, `running`=0, `mct_cnt`=0, state `STBY`.
- Reset is asynchronous and takes effect mid-pulse with no completion. Release is synchronous to the next clk edge.
- From `go` sampled high: `t`=T01 and `running`=1 on that same edge, so latency is 1 clk.
- MCT length is exactly 12×`PHASES` clk. No gaps between MCTs while in `RUN`.
- `stop` and `gojam` are registered-decision inputs: their effect is visible one edge after sampling.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `AGC_TPG_MSTEP_EN` defined: `mstep` port exists. In `HALT`, a `mstep` rising edge (internally edge-detected) runs exactly one MCT, T01..T12, then returns to `HALT` regardless of `stop`. `mstep` during `RUN` is ignored.
- Not defined: `mstep` port and edge detector are omitted. Behaviour is otherwise identical.

## Structure
- Shared package `agc_tpg_pkg`:
  - state enum (`STBY`, `RUN`, `HALT`);
  - constant `TP_COUNT`=12;
  - named one-hot constants `T01`..`T12`.
- One sub-module: `agc_tpg_phase`, the phase counter. It produces a `ph` wrap strobe that the ring rotation consumes. The ring and FSM stay in the top level.

## Test plan
- Reset then `go`=1, `PHASES`=2:
  - `t` sequence is 001, 001, 002, 002, … 800, 800, 001;
  - `mct_end` pulses every 24 clk;
  - `mct_cnt`=3 after 72 clk.
- `stop`=1 asserted during T05 of MCT 0:
  - T12 completes;
  - `t`=0 and `running`=0 on the next edge;
  - `mct_cnt`=1.
- `gojam` pulsed during T03: next `t`=T12 with `ph`=0; T01 follows after `PHASES` clk; `mct_cnt` +1.
- `rst` low during T07, `ph`=1: all outputs return to reset values asynchronously; release with `go`=0 stays in `STBY`.
- `mct_cnt` preloaded to 16'hFFFF by forcing, then one MCT: `mct_cnt`=0.
- `AGC_TPG_MSTEP_EN` defined, `stop`=1 in `HALT`: one `mstep` pulse yields exactly one T01..T12 pass; `mct_cnt` +1; `HALT` is re-entered; a held `mstep` level does not repeat.

Source files
------------

// File: rtl/agc_tpg_pkg.sv
// -----------------------------------------------------------------------------
// agc_tpg_pkg
// Shared definitions for the AGC time-pulse generator: the controller state
// encoding, the number of time pulses per memory cycle time and the one-hot
// patterns for each pulse T01..T12.
// -----------------------------------------------------------------------------
package agc_tpg_pkg;

    typedef enum logic [1:0] {
        STBY = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } tpg_state_e;

    localparam int TP_COUNT = 12;

    localparam logic [TP_COUNT-1:0] T01 = 12'h001;
    localparam logic [TP_COUNT-1:0] T02 = 12'h002;
    localparam logic [TP_COUNT-1:0] T03 = 12'h004;
    localparam logic [TP_COUNT-1:0] T04 = 12'h008;
    localparam logic [TP_COUNT-1:0] T05 = 12'h010;
    localparam logic [TP_COUNT-1:0] T06 = 12'h020;
    localparam logic [TP_COUNT-1:0] T07 = 12'h040;
    localparam logic [TP_COUNT-1:0] T08 = 12'h080;
    localparam logic [TP_COUNT-1:0] T09 = 12'h100;
    localparam logic [TP_COUNT-1:0] T10 = 12'h200;
    localparam logic [TP_COUNT-1:0] T11 = 12'h400;
    localparam logic [TP_COUNT-1:0] T12 = 12'h800;

    // Advance the one-hot ring by one pulse; T12 wraps back to T01.
    function automatic logic [TP_COUNT-1:0] rotate_tp(input logic [TP_COUNT-1:0] tp);
        return {tp[TP_COUNT-2:0], tp[TP_COUNT-1]};
    endfunction

endpackage

// File: rtl/agc_tpg_phase.sv
// -----------------------------------------------------------------------------
// agc_tpg_phase
// Phase counter for the time-pulse generator. Counts clk cycles within the
// current time pulse and flags the last phase so the ring can rotate.
//
// Ports:
//   clk    in   master clock
//   rst    in   asynchronous reset, active-low
//   enable in   count this cycle (generator running)
//   clear  in   force the phase back to 0 on the next edge
//   ph     out  current phase index, 0..PHASES-1
//   wrap   out  high in the last phase of a pulse while enabled
// -----------------------------------------------------------------------------
module agc_tpg_phase #(
    parameter int PHASES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    output logic [2:0] ph,
    output logic       wrap
);

    localparam logic [2:0] PH_LAST = 3'(PHASES - 1);

    // wrap is a decode of the registered phase only, so it carries no input path.
    assign wrap = enable && (ph == PH_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph <= '0;
        end else if (clear) begin
            ph <= '0;
        end else if (enable) begin
            ph <= wrap ? 3'd0 : ph + 3'd1;
        end
    end

endmodule

// File: rtl/agc_tpg.sv
// -----------------------------------------------------------------------------
// agc_tpg
// Time-pulse generator for the gate-level AGC model. Produces the one-hot time
// pulses T01..T12 of each memory cycle time (MCT) together with the phase
// index, handles power-on standby, GOJAM restart and monitor stop at MCT
// boundaries.
//
// Optional feature macro: AGC_TPG_MSTEP_EN adds the mstep input, which runs
// exactly one MCT from HALT on each rising edge.
//
// Ports:
//   clk      in   master clock
//   rst      in   asynchronous reset, active-low
//   go       in   leave standby and start running
//   gojam    in   restart request: jump to T12, then a fresh T01
//   stop     in   monitor stop, honoured at the end of an MCT
//   mstep    in   single-MCT step (AGC_TPG_MSTEP_EN only)
//   t        out  one-hot time pulse, bit 0 = T01, bit 11 = T12
//   ph       out  phase index within the current pulse
//   mct_end  out  strobe in the last phase of T12
//   running  out  high while in RUN
//   mct_cnt  out  completed-MCT counter, wraps modulo 2^16
// -----------------------------------------------------------------------------
module agc_tpg
    import agc_tpg_pkg::*;
#(
    parameter int                    PHASES = 2,
    parameter logic [TP_COUNT-1:0]   IV_T   = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic                gojam,
    input  logic                stop,
`ifdef AGC_TPG_MSTEP_EN
    input  logic                mstep,
`endif
    output logic [TP_COUNT-1:0] t,
    output logic [2:0]          ph,
    output logic                mct_end,
    output logic                running,
    output logic [15:0]         mct_cnt
);

    tpg_state_e          state;
    tpg_state_e          state_next;
    logic [TP_COUNT-1:0] t_next;
    logic                ph_wrap;
    logic                ph_clear;
    logic                cnt_inc;
    logic                step_active;
    logic                step_next;
    logic                mstep_edge;

    assign running = (state == RUN);
    assign mct_end = ph_wrap && (t == T12);

    agc_tpg_phase #(
        .PHASES (PHASES)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .enable (running),
        .clear  (ph_clear),
        .ph     (ph),
        .wrap   (ph_wrap)
    );

`ifdef AGC_TPG_MSTEP_EN
    // Edge detect on mstep so a held level cannot start a second MCT.
    logic mstep_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstep_q <= 1'b0;
        end else begin
            mstep_q <= mstep;
        end
    end

    assign mstep_edge = mstep && !mstep_q;
`else
    assign mstep_edge = 1'b0;
`endif

    // Next-state logic. stop is only looked at in the mct_end cycle so that
    // T12 always completes; a GOJAM jump clears the phase so T12 runs its
    // full length. A step MCT always ends back in HALT.
    always_comb begin
        state_next = state;
        t_next     = t;
        ph_clear   = 1'b0;
        cnt_inc    = 1'b0;
        step_next  = step_active;
        unique case (state)
            STBY: begin
                ph_clear = 1'b1;
                if (go) begin
                    state_next = RUN;
                    t_next     = T01;
                end
            end
            RUN: begin
                if (mct_end) begin
                    cnt_inc = 1'b1;
                    if (stop || step_active) begin
                        state_next = HALT;
                        t_next     = '0;
                        step_next  = 1'b0;
                    end else begin
                        t_next = T01;
                    end
                end else if (gojam && (t != T12)) begin
                    t_next   = T12;
                    ph_clear = 1'b1;
                end else if (ph_wrap) begin
                    t_next = rotate_tp(t);
                end
            end
            HALT: begin
                ph_clear = 1'b1;
                if (mstep_edge) begin
                    state_next = RUN;
                    t_next     = T01;
                    step_next  = 1'b1;
                end else if (!stop) begin
                    state_next = RUN;
                    t_next     = T01;
                end
            end
            default: begin
                state_next = STBY;
                t_next     = '0;
                ph_clear   = 1'b1;
                step_next  = 1'b0;
            end
        endcase
    end

    // Controller state, time-pulse ring and step flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= STBY;
            t           <= IV_T;
            step_active <= 1'b0;
        end else begin
            state       <= state_next;
            t           <= t_next;
            step_active <= step_next;
        end
    end

    // Completed-MCT counter, advanced on the edge that leaves T12.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mct_cnt <= '0;
        end else if (cnt_inc) begin
            mct_cnt <= mct_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_agc_tpg.sv
// -----------------------------------------------------------------------------
// tb_agc_tpg
// Directed testbench for agc_tpg with PHASES=2: free-running sequence, monitor
// stop, GOJAM restart, asynchronous reset mid-pulse, counter wrap and, when
// AGC_TPG_MSTEP_EN is defined, single-MCT stepping.
// -----------------------------------------------------------------------------
module tb_agc_tpg;

    localparam int PH = 2;

    logic        clk;
    logic        rst;
    logic        go;
    logic        gojam;
    logic        stop;
`ifdef AGC_TPG_MSTEP_EN
    logic        mstep;
`endif
    logic [11:0] t;
    logic [2:0]  ph;
    logic        mct_end;
    logic        running;
    logic [15:0] mct_cnt;

    int checks;
    int passes;

    agc_tpg #(
        .PHASES (PH),
        .IV_T   (12'h000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .gojam   (gojam),
        .stop    (stop),
`ifdef AGC_TPG_MSTEP_EN
        .mstep   (mstep),
`endif
        .t       (t),
        .ph      (ph),
        .mct_end (mct_end),
        .running (running),
        .mct_cnt (mct_cnt)
    );

    // 10 ns master clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input logic g, input logic gj, input logic s);
        go    = g;
        gojam = gj;
        stop  = s;
    endtask

    // Advance n clocks, landing on a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Enter RUN from STBY: go high for one edge, then low again.
    task automatic startRun();
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic resetDut();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    // Expected pulse for clock n of a run that started at T01, phase 0.
    function automatic logic [11:0] expT(input int n);
        logic [11:0] one;
        one = 12'h001;
        return one << ((n / PH) % 12);
    endfunction

    initial begin
        checks = 0;
        passes = 0;
        rst    = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
`ifdef AGC_TPG_MSTEP_EN
        mstep  = 1'b0;
`endif

        // Reset values.
        #12;
        checkOutput("rst_t",       32'(t),       32'h000);
        checkOutput("rst_ph",      32'(ph),      32'd0);
        checkOutput("rst_mct_end", 32'(mct_end), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_mct_cnt", 32'(mct_cnt), 32'd0);

        // Released with go low: stays in standby.
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        checkOutput("stby_running", 32'(running), 32'd0);
        checkOutput("stby_t",       32'(t),       32'h000);

        // Free run for three full MCTs; go dropping in RUN has no effect.
        startRun();
        for (int n = 0; n <= 72; n++) begin
            checkOutput("seq_t",       32'(t),       32'(expT(n)));
            checkOutput("seq_ph",      32'(ph),      32'(n % PH));
            checkOutput("seq_mct_end", 32'(mct_end), 32'((n % 24) == 23));
            checkOutput("seq_mct_cnt", 32'(mct_cnt), 32'(n / 24));
            checkOutput("seq_running", 32'(running), 32'd1);
            if (n < 72) tick(1);
        end
        checkOutput("cnt_after_72", 32'(mct_cnt), 32'd3);

        // Monitor stop raised during T05: T12 still completes.
        resetDut();
        startRun();
        tick(8);
        checkOutput("stop_at_t05", 32'(t), 32'h010);
        stop = 1'b1;
        tick(2);
        checkOutput("stop_mid_t",       32'(t),       32'h020);
        checkOutput("stop_mid_running", 32'(running), 32'd1);
        tick(13);
        checkOutput("stop_end_strobe", 32'(mct_end), 32'd1);
        checkOutput("stop_end_t",      32'(t),       32'h800);
        tick(1);
        checkOutput("halt_t",       32'(t),       32'h000);
        checkOutput("halt_running", 32'(running), 32'd0);
        checkOutput("halt_mct_cnt", 32'(mct_cnt), 32'd1);
        tick(3);
        checkOutput("halt_hold_t", 32'(t), 32'h000);
        stop = 1'b0;
        tick(1);
        checkOutput("resume_t",       32'(t),       32'h001);
        checkOutput("resume_ph",      32'(ph),      32'd0);
        checkOutput("resume_running", 32'(running), 32'd1);

        // GOJAM in T03: jump to T12 phase 0, then T01.
        tick(4);
        checkOutput("gojam_pre_t", 32'(t), 32'h004);
        gojam = 1'b1;
        tick(1);
        gojam = 1'b0;
        checkOutput("gojam_t",       32'(t),       32'h800);
        checkOutput("gojam_ph",      32'(ph),      32'd0);
        checkOutput("gojam_mct_end", 32'(mct_end), 32'd0);
        tick(1);
        checkOutput("gojam_end_strobe", 32'(mct_end), 32'd1);
        tick(1);
        checkOutput("gojam_next_t",   32'(t),       32'h001);
        checkOutput("gojam_next_ph",  32'(ph),      32'd0);
        checkOutput("gojam_mct_cnt",  32'(mct_cnt), 32'd2);

        // GOJAM while already in T12: no jump, phase keeps counting.
        tick(22);
        checkOutput("gj12_pre_t", 32'(t), 32'h800);
        gojam = 1'b1;
        tick(1);
        gojam = 1'b0;
        checkOutput("gj12_t",  32'(t),  32'h800);
        checkOutput("gj12_ph", 32'(ph), 32'd1);
        tick(1);
        checkOutput("gj12_next_t",  32'(t),       32'h001);
        checkOutput("gj12_mct_cnt", 32'(mct_cnt), 32'd3);

        // Asynchronous reset in T07 phase 1.
        tick(13);
        checkOutput("arst_pre_t",  32'(t),  32'h040);
        checkOutput("arst_pre_ph", 32'(ph), 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_t",       32'(t),       32'h000);
        checkOutput("arst_ph",      32'(ph),      32'd0);
        checkOutput("arst_mct_end", 32'(mct_end), 32'd0);
        checkOutput("arst_running", 32'(running), 32'd0);
        checkOutput("arst_mct_cnt", 32'(mct_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        checkOutput("arst_stby_running", 32'(running), 32'd0);
        checkOutput("arst_stby_t",       32'(t),       32'h000);

        // Counter wrap from 16'hFFFF.
        startRun();
        tick(1);
        force dut.mct_cnt = 16'hFFFF;
        tick(1);
        release dut.mct_cnt;
        checkOutput("wrap_pre_cnt", 32'(mct_cnt), 32'hFFFF);
        tick(21);
        checkOutput("wrap_end_strobe", 32'(mct_end), 32'd1);
        tick(1);
        checkOutput("wrap_cnt", 32'(mct_cnt), 32'd0);
        checkOutput("wrap_t",   32'(t),       32'h001);

`ifdef AGC_TPG_MSTEP_EN
        // Single step from HALT with stop held high.
        stop = 1'b1;
        tick(24);
        checkOutput("step_halt_running", 32'(running), 32'd0);
        checkOutput("step_halt_cnt",     32'(mct_cnt), 32'd1);
        mstep = 1'b1;
        tick(1);
        checkOutput("step_t01",     32'(t),       32'h001);
        checkOutput("step_running", 32'(running), 32'd1);
        tick(10);
        checkOutput("step_mid_t", 32'(t), 32'h020);
        tick(13);
        checkOutput("step_end_strobe", 32'(mct_end), 32'd1);
        checkOutput("step_end_t",      32'(t),       32'h800);
        tick(1);
        checkOutput("step_back_running", 32'(running), 32'd0);
        checkOutput("step_back_t",       32'(t),       32'h000);
        checkOutput("step_back_cnt",     32'(mct_cnt), 32'd2);
        tick(30);
        checkOutput("step_held_running", 32'(running), 32'd0);
        checkOutput("step_held_cnt",     32'(mct_cnt), 32'd2);
        mstep = 1'b0;
        tick(2);
        checkOutput("step_low_running", 32'(running), 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
